// File: rtl/midi_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : midi_uart_rx
//  Description : MIDI DIN serial receiver, 8N1, LSB first, line idle high.
//                Double-synchronises the line, rejects start-bit glitches,
//                delivers each well-framed byte with a one-cycle valid_byte
//                strobe and flags bad stop bits with a one-cycle frame_err.
//  Ports       : clk        - system clock (single domain)
//                rst        - synchronous active-high reset
//                rx         - asynchronous serial line, idle high
//                valid_byte - one-cycle pulse, data holds a new good byte
//                data[7:0]  - last good byte, stable between strobes
//                frame_err  - one-cycle pulse, stop bit sampled low
//                busy       - high whenever the receiver is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module midi_uart_rx #(
    parameter int CLKS_PER_BIT = 1600,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       valid_byte,
    output logic [7:0] data,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    localparam logic [15:0] c_half_last = 16'(HALF_BIT - 1);
    localparam logic [15:0] c_bit_last  = 16'(CLKS_PER_BIT - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic        r_rx_meta;
    logic        r_rx_s;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_ferr;
    logic        w_tick;
    logic        w_valid_nxt;
    logic        w_ferr_nxt;

    // Sample strike: the counter has run a full half/whole bit since it was
    // last cleared, so this cycle lands on the bit centre.
    always_comb begin
        w_tick = 1'b0;
        case (r_state)
            S_START:        w_tick = (r_cnt == c_half_last);
            S_DATA, S_STOP: w_tick = (r_cnt == c_bit_last);
            default:        w_tick = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) w_state_nxt = S_START;
            end
            S_START: begin
                // Line back high at the start-bit centre means a glitch.
                if (w_tick) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_tick && (r_bit_idx == 3'd7)) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_rx_s) begin
                        w_state_nxt = S_IDLE;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_BREAK;
                        w_ferr_nxt  = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                // Hold off new starts until the line has returned high.
                if (r_rx_s) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_cnt     <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_state   <= w_state_nxt;
            r_valid   <= w_valid_nxt;
            r_ferr    <= w_ferr_nxt;

            // Counter restarts on every state change and at every sample so
            // each sample sits exactly one bit period after the previous one.
            if ((w_state_nxt != r_state) || w_tick ||
                (r_state == S_IDLE) || (r_state == S_BREAK)) begin
                r_cnt <= 16'd0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (r_state == S_START) begin
                r_bit_idx <= 3'd0;
            end else if ((r_state == S_DATA) && w_tick) begin
                r_shift[r_bit_idx] <= r_rx_s;
                r_bit_idx          <= r_bit_idx + 3'd1;
            end

            if (w_valid_nxt) r_data <= r_shift;
        end
    end

    assign valid_byte = r_valid;
    assign frame_err  = r_ferr;
    assign data       = r_data;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_midi_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_midi_uart_rx
//  Description : Self-checking bench for midi_uart_rx with CLKS_PER_BIT=16.
//                Table of single frames plus hand-written multi-cycle
//                sequences (reset idle, back-to-back, glitch, mid-frame
//                reset, short inter-frame gap).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_midi_uart_rx;

    localparam int c_cpb  = 16;
    localparam int c_half = c_cpb / 2;
    localparam int c_lat  = 3 + c_half + 9 * c_cpb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       valid_byte;
    logic [7:0] data;
    logic       frame_err;
    logic       busy;

    midi_uart_rx #(.CLKS_PER_BIT(c_cpb)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .valid_byte (valid_byte),
        .data       (data),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor sampled on the falling edge, away from the active edge.
    int n_valid = 0, n_ferr = 0, n_busy = 0, n_wide = 0, n_both = 0;
    logic prev_valid = 1'b0, prev_ferr = 1'b0;
    logic [7:0] data_q[$];
    int stamp_q[$];
    int fall_q[$];

    always @(negedge clk) begin
        if (valid_byte) begin
            n_valid++;
            data_q.push_back(data);
            stamp_q.push_back(cyc);
            if (prev_valid) n_wide++;
        end
        if (frame_err) begin
            n_ferr++;
            if (prev_ferr) n_wide++;
        end
        if (valid_byte && frame_err) n_both++;
        if (busy) n_busy++;
        prev_valid = valid_byte;
        prev_ferr  = frame_err;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_near(input string name, input int act, input int exp);
        n_checks++;
        if ((act < exp - 1) || (act > exp + 1)) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d +/-1", name, act, exp);
        end
    endtask

    // All stimulus is applied 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        rx = 1'b0;
        fall_q.push_back(cyc);
        for (int i = 0; i < 8; i++) begin
            idle(c_cpb);
            rx = b[i];
        end
        idle(c_cpb);
        rx = stop_val;
        idle(c_cpb);
    endtask

    typedef struct {
        logic [7:0] tx;
        logic       stop_low;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    int v0, f0, b0;

    initial begin
        vecs[0] = '{tx: 8'h55, stop_low: 1'b0, exp_valid: 1, exp_ferr: 0, exp_data: 8'h55};
        vecs[1] = '{tx: 8'hA5, stop_low: 1'b1, exp_valid: 0, exp_ferr: 1, exp_data: 8'h55};
        vecs[2] = '{tx: 8'h0F, stop_low: 1'b0, exp_valid: 1, exp_ferr: 0, exp_data: 8'h0F};
        vecs[3] = '{tx: 8'h80, stop_low: 1'b0, exp_valid: 1, exp_ferr: 0, exp_data: 8'h80};
        vecs[4] = '{tx: 8'hFF, stop_low: 1'b0, exp_valid: 1, exp_ferr: 0, exp_data: 8'hFF};
        vecs[5] = '{tx: 8'h00, stop_low: 1'b0, exp_valid: 1, exp_ferr: 0, exp_data: 8'h00};
        vecs[6] = '{tx: 8'h01, stop_low: 1'b1, exp_valid: 0, exp_ferr: 1, exp_data: 8'h00};

        // ---- 1. reset, then idle line ----
        rst = 1'b1;
        rx  = 1'b1;
        idle(3);
        check("reset_data", int'(data), 8'h00);
        check("reset_valid", int'(valid_byte), 0);
        check("reset_ferr", int'(frame_err), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;
        v0 = n_valid; f0 = n_ferr; b0 = n_busy;
        idle(1000);
        check("idle_valid", n_valid - v0, 0);
        check("idle_ferr", n_ferr - f0, 0);
        check("idle_busy", n_busy - b0, 0);
        check("idle_data", int'(data), 8'h00);

        // ---- 2. back-to-back note-on 0x90 0x3C 0x64 ----
        data_q.delete(); stamp_q.delete(); fall_q.delete();
        v0 = n_valid;
        send_frame(8'h90, 1'b1);
        send_frame(8'h3C, 1'b1);
        send_frame(8'h64, 1'b1);
        idle(20);
        check("b2b_count", n_valid - v0, 3);
        if (data_q.size() >= 3 && fall_q.size() >= 3) begin
            check("b2b_data0", int'(data_q[0]), 8'h90);
            check("b2b_data1", int'(data_q[1]), 8'h3C);
            check("b2b_data2", int'(data_q[2]), 8'h64);
            for (int i = 0; i < 3; i++)
                check_near("b2b_latency", stamp_q[i] - fall_q[i], c_lat);
        end else begin
            n_checks++;
            n_errors++;
            $display("FAIL b2b_queue: got %0d bytes, expected 3", data_q.size());
        end

        // ---- 3. start-bit glitch ----
        v0 = n_valid; f0 = n_ferr; b0 = n_busy;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        check("glitch_busy_seen", int'(n_busy - b0 > 0), 1);
        check("glitch_valid", n_valid - v0, 0);
        check("glitch_ferr", n_ferr - f0, 0);
        check("glitch_busy_end", int'(busy), 0);

        // ---- table: single frames, including framing errors ----
        foreach (vecs[i]) begin
            v0 = n_valid; f0 = n_ferr;
            send_frame(vecs[i].tx, !vecs[i].stop_low);
            if (vecs[i].stop_low) begin
                idle(40);
                rx = 1'b1;
            end
            idle(20);
            check($sformatf("vec%0d_valid", i), n_valid - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d_ferr", i), n_ferr - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_data", i), int'(data), int'(vecs[i].exp_data));
            check($sformatf("vec%0d_busy", i), int'(busy), 0);
        end

        // ---- 5. reset in the middle of bit 4 of 0xFF ----
        v0 = n_valid; f0 = n_ferr;
        rx = 1'b0;
        idle(c_cpb);
        rx = 1'b1;
        idle(4 * c_cpb + c_half);
        check("midreset_busy_before", int'(busy), 1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midreset_busy_after", int'(busy), 0);
        idle(200);
        check("midreset_valid", n_valid - v0, 0);
        check("midreset_ferr", n_ferr - f0, 0);
        check("midreset_data", int'(data), 8'h00);
        send_frame(8'hFF, 1'b1);
        idle(20);
        check("postreset_valid", n_valid - v0, 1);
        check("postreset_data", int'(data), 8'hFF);

        // ---- 6. 0xFF then 0x00, start edge 8 cycles after stop centre ----
        data_q.delete();
        v0 = n_valid;
        send_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1);
        idle(20);
        check("gap_count", n_valid - v0, 2);
        if (data_q.size() >= 2) begin
            check("gap_data0", int'(data_q[0]), 8'hFF);
            check("gap_data1", int'(data_q[1]), 8'h00);
        end else begin
            n_checks++;
            n_errors++;
            $display("FAIL gap_queue: got %0d bytes, expected 2", data_q.size());
        end

        // ---- strobe shape over the whole run ----
        check("strobe_width", n_wide, 0);
        check("strobe_overlap", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
